// File: rtl/qspi_rd_buffer.sv
// Read-data buffer between the QSPI sample register and the AHB slave: an edge-triggered push into a FWFT FIFO on h_clk.
// Build option: define RD_BUF_BYTE_SWAP_EN to byte-reverse each word on write (flash MSB-first -> little-endian).
module qspi_rd_buffer #(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 32,
    parameter int AF_MARG = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              h_clk,
    input  logic              h_rstn,
    input  logic [DATA_W-1:0] data_sample_reg_in,
    input  logic              wr_en_in,
    input  logic              rd_en_in,
    input  logic              flush_in,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              empty_out,
    output logic              full_out,
    output logic              almost_full_out,
    output logic [AW:0]       level_out,
    output logic              overflow_out,
    output logic              underflow_out
);

    localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - AF_MARG);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        empty_q, full_q, af_q;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        wr_en_q;
    logic        wr_arm_q;
    logic        push, accept_push, accept_pop;
    logic [DATA_W-1:0] wr_word;

    // Handshake: wr_en_in is a level "word ready"; exactly one word is taken on each
    // rising edge of it (never while it was already high out of reset). rd_en_in pops
    // the head shown on rd_data_out whenever empty_out is low; pops on empty are ignored.
    assign push        = wr_en_in & ~wr_en_q & wr_arm_q;
    assign accept_pop  = rd_en_in & ~empty_q & ~flush_in;
    assign accept_push = push & ~flush_in & (~full_q | accept_pop);

`ifdef RD_BUF_BYTE_SWAP_EN
    always_comb begin
        wr_word = '0;
        for (int i = 0; i < DATA_W/8; i++) begin
            wr_word[8*i +: 8] = data_sample_reg_in[DATA_W-8-8*i +: 8];
        end
    end
`else
    assign wr_word = data_sample_reg_in;
`endif

    // The arm bit stays low until wr_en_in is seen low, so a level held across reset never pushes.
    always_ff @(posedge h_clk or negedge h_rstn) begin
        if (!h_rstn) begin
            wr_en_q  <= 1'b0;
            wr_arm_q <= 1'b0;
        end else begin
            wr_en_q  <= wr_en_in;
            if (!wr_en_in) wr_arm_q <= 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (accept_push)      wr_ptr_d = wr_ptr_q + 1'b1;
            else if (push)        ovf_d    = 1'b1;
            if (accept_pop)       rd_ptr_d = rd_ptr_q + 1'b1;
            else if (rd_en_in)    unf_d    = 1'b1;
            level_d = level_q + (AW+1)'(accept_push) - (AW+1)'(accept_pop);
        end
    end

    // Flags are computed from the next pointers so they change on the same edge.
    always_ff @(posedge h_clk or negedge h_rstn) begin
        if (!h_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= (wr_ptr_d == rd_ptr_d);
            full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                        (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
            af_q     <= (level_d >= AF_LEVEL);
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge h_clk) begin
        if (accept_push) mem[wr_ptr_q[AW-1:0]] <= wr_word;
    end

    assign rd_data_out     = empty_q ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign empty_out       = empty_q;
    assign full_out        = full_q;
    assign almost_full_out = af_q;
    assign level_out       = level_q;
    assign overflow_out    = ovf_q;
    assign underflow_out   = unf_q;

endmodule

// File: tb/tb_qspi_rd_buffer.sv
// Bench for qspi_rd_buffer: single-cycle vector table plus scripted fill/drain, flush and async-reset sequences.
module tb_qspi_rd_buffer;

    logic        h_clk = 1'b0;
    logic        h_rstn = 1'b0;
    logic [31:0] data_sample_reg_in = '0;
    logic        wr_en_in = 1'b0;
    logic        rd_en_in = 1'b0;
    logic        flush_in = 1'b0;
    logic [31:0] rd_data_out;
    logic        empty_out, full_out, almost_full_out;
    logic [4:0]  level_out;
    logic        overflow_out, underflow_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic        fl;
        logic [31:0] data;
        int          exp_level;
        logic        exp_empty;
        logic        exp_unf;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl[$];

    qspi_rd_buffer dut (
        .h_clk              (h_clk),
        .h_rstn             (h_rstn),
        .data_sample_reg_in (data_sample_reg_in),
        .wr_en_in           (wr_en_in),
        .rd_en_in           (rd_en_in),
        .flush_in           (flush_in),
        .rd_data_out        (rd_data_out),
        .empty_out          (empty_out),
        .full_out           (full_out),
        .almost_full_out    (almost_full_out),
        .level_out          (level_out),
        .overflow_out       (overflow_out),
        .underflow_out      (underflow_out)
    );

    // clock / reset
    always #5 h_clk = ~h_clk;

    function automatic logic [31:0] sw(input logic [31:0] d);
`ifdef RD_BUF_BYTE_SWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int lvl, input logic emp, input logic full,
                             input logic af, input logic ovf, input logic unf, input logic [31:0] rd);
        chk({name, ".level"}, 32'(level_out), 32'(lvl));
        chk({name, ".empty"}, 32'(empty_out), 32'(emp));
        chk({name, ".full"},  32'(full_out),  32'(full));
        chk({name, ".af"},    32'(almost_full_out), 32'(af));
        chk({name, ".ovf"},   32'(overflow_out),  32'(ovf));
        chk({name, ".unf"},   32'(underflow_out), 32'(unf));
        chk({name, ".rdata"}, rd_data_out, rd);
    endtask

    task automatic add(input logic wr, input logic rd, input logic fl, input logic [31:0] data,
                       input int lvl, input logic emp, input logic unf, input logic [31:0] exp_rd);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.data = data;
        v.exp_level = lvl; v.exp_empty = emp; v.exp_unf = unf; v.exp_rd = exp_rd;
        tbl.push_back(v);
    endtask

    // driver tasks: all start and end at posedge+1
    task automatic step();
        @(posedge h_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        data_sample_reg_in = d;
        wr_en_in = 1'b1;
        step();
        wr_en_in = 1'b0;
        step();
    endtask

    task automatic pop_word();
        rd_en_in = 1'b1;
        step();
        rd_en_in = 1'b0;
    endtask

    task automatic flush();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
    endtask

    initial begin
        // single-cycle vectors, starting from an empty, flag-free FIFO
        add(0, 1, 0, 32'h0, 0, 1, 1, 32'h0);
        add(1, 1, 0, 32'h5, 1, 0, 1, sw(32'h5));
        add(0, 0, 0, 32'h0, 1, 0, 1, sw(32'h5));
        add(1, 0, 0, 32'h6, 2, 0, 1, sw(32'h5));
        add(0, 1, 0, 32'h0, 1, 0, 1, sw(32'h6));
        add(1, 0, 1, 32'h7, 0, 1, 0, 32'h0);
        add(1, 0, 0, 32'h7, 0, 1, 0, 32'h0);
        add(0, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        add(1, 0, 0, 32'h8, 1, 0, 0, sw(32'h8));
        add(0, 1, 0, 32'h0, 0, 1, 0, 32'h0);

        // reset with wr_en already high
        wr_en_in = 1'b1;
        data_sample_reg_in = 32'hCAFE0001;
        #12;
        check_all("reset", 0, 1, 0, 0, 0, 0, 32'h0);
        step();
        h_rstn = 1'b1;
        repeat (3) step();
        chk("wr_high_at_reset.level", 32'(level_out), 32'd0);

        // one push for a long wr_en pulse
        wr_en_in = 1'b0;
        step();
        data_sample_reg_in = 32'h11223344;
        wr_en_in = 1'b1;
        step();
        chk("latency.empty", 32'(empty_out), 32'd0);
        repeat (7) step();
        wr_en_in = 1'b0;
        check_all("long_pulse", 1, 0, 0, 0, 0, 0, sw(32'h11223344));
        step();

        // fill to full, checking almost_full and full thresholds
        flush();
        check_all("flush1", 0, 1, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            push_word(32'(i));
            exp_q.push_back(32'(i));
            chk($sformatf("fill%0d.level", i), 32'(level_out), 32'(i + 1));
            chk($sformatf("fill%0d.af", i), 32'(almost_full_out), 32'(i + 1 >= 14));
            chk($sformatf("fill%0d.full", i), 32'(full_out), 32'(i + 1 == 16));
        end

        // pop + push while full
        rd_en_in = 1'b1;
        wr_en_in = 1'b1;
        data_sample_reg_in = 32'hAA;
        step();
        rd_en_in = 1'b0;
        wr_en_in = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(32'hAA);
        check_all("full_pop_push", 16, 0, 1, 1, 0, 0, sw(32'h1));
        step();

        // push while full is dropped
        push_word(32'hDEADBEEF);
        check_all("overflow", 16, 0, 1, 1, 1, 0, sw(32'h1));

        // drain against the scoreboard
        for (int i = 0; i < 16; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk($sformatf("drain%0d", i), rd_data_out, sw(e));
            pop_word();
        end
        check_all("drained", 0, 1, 0, 0, 1, 0, 32'h0);

        // table-driven single-cycle corner cases
        flush();
        for (int i = 0; i < tbl.size(); i++) begin
            wr_en_in = tbl[i].wr;
            rd_en_in = tbl[i].rd;
            flush_in = tbl[i].fl;
            data_sample_reg_in = tbl[i].data;
            step();
            check_all($sformatf("vec%0d", i), tbl[i].exp_level, tbl[i].exp_empty, 1'b0, 1'b0,
                      1'b0, tbl[i].exp_unf, tbl[i].exp_rd);
        end
        wr_en_in = 1'b0;
        rd_en_in = 1'b0;
        step();

        // level 5 with both sticky flags, then flush with a coincident push edge
        pop_word();
        for (int i = 0; i < 17; i++) push_word(32'h100 + 32'(i));
        for (int i = 0; i < 11; i++) pop_word();
        check_all("pre_flush", 5, 0, 0, 0, 1, 1, sw(32'h10B));
        flush_in = 1'b1;
        wr_en_in = 1'b1;
        data_sample_reg_in = 32'h77;
        step();
        flush_in = 1'b0;
        check_all("flush_push", 0, 1, 0, 0, 0, 0, 32'h0);
        step();
        chk("flush_push_lost.level", 32'(level_out), 32'd0);
        wr_en_in = 1'b0;
        step();

        // asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) push_word(32'h200 + 32'(i));
        chk("pre_reset.level", 32'(level_out), 32'd7);
        #2;
        h_rstn = 1'b0;
        #1;
        check_all("async_reset", 0, 1, 0, 0, 0, 0, 32'h0);
        step();
        h_rstn = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
